// File: rtl/flush_ctrl_if.sv
// rtl/flush_ctrl_if.sv - redirect handshake between flush_ctrl and the fetch stage
interface flush_ctrl_if;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic [1:0]  flush_cause;

    modport master (
        output redirect_valid,
        output redirect_pc,
        output flush_cause,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        input  flush_cause,
        output redirect_ready
    );
endinterface

// File: rtl/flush_ctrl.sv
// rtl/flush_ctrl.sv - commit-side flush sequencer: flush pulse, cacop wait, redirect to fetch
module flush_ctrl #(
    parameter int FLUSH_HOLD = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         excp_flush,
    input  logic         ertn_flush,
    input  logic         refetch_flush,
    input  logic         icacop_flush,
    input  logic         excp_tlbrefill,
    input  logic [31:0]  ws_pc,
    input  logic [31:0]  csr_eentry,
    input  logic [31:0]  csr_tlbrentry,
    input  logic [31:0]  csr_era_value,
    input  logic         icache_cacop_done,
    output logic         pipe_flush,
    output logic         flush_busy,
    flush_ctrl_if.master redir
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLUSH      = 2'd1,
        WAIT_CACOP = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_EXCP    = 2'd0;
    localparam logic [1:0] CAUSE_ERTN    = 2'd1;
    localparam logic [1:0] CAUSE_ICACOP  = 2'd2;
    localparam logic [1:0] CAUSE_REFETCH = 2'd3;
    localparam logic [3:0] HOLD_INIT     = 4'(FLUSH_HOLD - 1);

    state_t      state;
    logic [3:0]  hold_cnt;
    logic [1:0]  cause;
    logic [31:0] target;
    logic        cacop_pending;
    logic        cacop_seen;
    logic        redirect_valid_q;

    logic any_flush;
    assign any_flush = excp_flush | ertn_flush | icacop_flush | refetch_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            hold_cnt         <= 4'd0;
            cause            <= 2'd0;
            target           <= 32'd0;
            cacop_pending    <= 1'b0;
            cacop_seen       <= 1'b0;
            pipe_flush       <= 1'b0;
            flush_busy       <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_flush) begin
                        state         <= FLUSH;
                        hold_cnt      <= HOLD_INIT;
                        cacop_seen    <= 1'b0;
                        cacop_pending <= 1'b0;
                        pipe_flush    <= 1'b1;
                        flush_busy    <= 1'b1;
                        if (excp_flush) begin
                            cause  <= CAUSE_EXCP;
                            target <= excp_tlbrefill ? csr_tlbrentry : csr_eentry;
                        end else if (ertn_flush) begin
                            cause  <= CAUSE_ERTN;
                            target <= csr_era_value;
                        end else if (icacop_flush) begin
                            cause         <= CAUSE_ICACOP;
                            target        <= ws_pc + 32'd4;
                            cacop_pending <= 1'b1;
                        end else begin
                            cause  <= CAUSE_REFETCH;
                            target <= ws_pc + 32'd4;
                        end
                    end
                end
                FLUSH: begin
                    if (cacop_pending && icache_cacop_done) begin
                        cacop_seen <= 1'b1;
                    end
                    if (hold_cnt == 4'd0) begin
                        pipe_flush <= 1'b0;
                        // a done arriving in the last flush cycle counts as already seen
                        if (cacop_pending && !cacop_seen && !icache_cacop_done) begin
                            state <= WAIT_CACOP;
                        end else begin
                            state            <= REDIRECT;
                            redirect_valid_q <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                WAIT_CACOP: begin
                    if (icache_cacop_done) begin
                        state            <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir.redirect_ready) begin
                        state            <= IDLE;
                        redirect_valid_q <= 1'b0;
                        flush_busy       <= 1'b0;
                        cacop_pending    <= 1'b0;
                        cacop_seen       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign redir.redirect_valid = redirect_valid_q;
    assign redir.redirect_pc    = target;
    assign redir.flush_cause    = cause;

endmodule

// File: tb/tb_flush_ctrl.sv
// tb/tb_flush_ctrl.sv - self-checking bench for flush_ctrl: vector table, corner sequences, random vs model
module tb_flush_ctrl;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        excp_flush = 1'b0, ertn_flush = 1'b0, refetch_flush = 1'b0, icacop_flush = 1'b0;
    logic        excp_tlbrefill = 1'b0;
    logic [31:0] ws_pc = 32'd0, csr_eentry = 32'd0, csr_tlbrentry = 32'd0, csr_era_value = 32'd0;
    logic        icache_cacop_done = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        pipe_flush, flush_busy;

    flush_ctrl_if rif();
    assign rif.redirect_ready = redirect_ready;

    flush_ctrl #(.FLUSH_HOLD(HOLD)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .refetch_flush     (refetch_flush),
        .icacop_flush      (icacop_flush),
        .excp_tlbrefill    (excp_tlbrefill),
        .ws_pc             (ws_pc),
        .csr_eentry        (csr_eentry),
        .csr_tlbrentry     (csr_tlbrentry),
        .csr_era_value     (csr_era_value),
        .icache_cacop_done (icache_cacop_done),
        .pipe_flush        (pipe_flush),
        .flush_busy        (flush_busy),
        .redir             (rif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: one outstanding flush described by its accept edge and the edge the cacop done was seen.
    bit          m_busy, m_cacop;
    int          m_acc, m_done;
    logic [1:0]  m_cause;
    logic [31:0] m_pc;

    function automatic int redirect_start();
        if (!m_cacop) return m_acc + HOLD;
        if (m_done < 0) return -1;
        return (m_done > m_acc + HOLD) ? m_done : m_acc + HOLD;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cacop = 0; m_acc = 0; m_done = -1; m_cause = 2'd0; m_pc = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int rs;
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            model_reset();
        end else if (!m_busy) begin
            if (excp_flush | ertn_flush | icacop_flush | refetch_flush) begin
                m_busy = 1; m_acc = cyc; m_done = -1; m_cacop = 0;
                if (excp_flush) begin
                    m_cause = 2'd0; m_pc = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
                end else if (ertn_flush) begin
                    m_cause = 2'd1; m_pc = csr_era_value;
                end else if (icacop_flush) begin
                    m_cause = 2'd2; m_pc = ws_pc + 32'd4; m_cacop = 1;
                end else begin
                    m_cause = 2'd3; m_pc = ws_pc + 32'd4;
                end
            end
        end else begin
            if (m_cacop && icache_cacop_done && m_done < 0) m_done = cyc;
            rs = redirect_start();
            if (rs >= 0 && rs <= cyc - 1 && redirect_ready) m_busy = 0;
        end
        @(negedge clk);
        rs = redirect_start();
        chk("pipe_flush", 32'(pipe_flush), 32'(m_busy && cyc < m_acc + HOLD));
        chk("flush_busy", 32'(flush_busy), 32'(m_busy));
        chk("redirect_valid", 32'(rif.redirect_valid), 32'(m_busy && rs >= 0 && cyc >= rs));
        chk("redirect_pc", rif.redirect_pc, m_pc);
        chk("flush_cause", 32'(rif.flush_cause), 32'(m_cause));
    endtask

    task automatic clear_flush();
        excp_flush = 0; ertn_flush = 0; refetch_flush = 0; icacop_flush = 0;
    endtask

    typedef struct {
        logic        e, r, i, f, tlb, done;
        logic [31:0] pc, eent, tlbr, era, exp_pc;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0, rv_at, idle_at, pf_n, n;
        logic [31:0] got_pc;
        logic [1:0]  got_cause;

        vecs[0] = '{1,0,0,0,0,0, 32'h0, 32'h1C008000, 32'h0, 32'h0, 32'h1C008000, 2'd0};
        vecs[1] = '{1,0,0,1,1,0, 32'h1C000200, 32'h1C008000, 32'h1C00F000, 32'h0, 32'h1C00F000, 2'd0};
        vecs[2] = '{0,1,1,1,0,0, 32'h1C000300, 32'h0, 32'h0, 32'h1C000040, 32'h1C000040, 2'd1};
        vecs[3] = '{0,0,0,1,0,0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h00000000, 2'd3};
        vecs[4] = '{0,0,1,1,0,1, 32'h1C000100, 32'h0, 32'h0, 32'h0, 32'h1C000104, 2'd2};
        vecs[5] = '{0,1,0,1,0,0, 32'h1C000500, 32'h0, 32'h0, 32'h1C0000A0, 32'h1C0000A0, 2'd1};

        model_reset();
        repeat (3) tick();
        chk("reset_pipe_flush", 32'(pipe_flush), 32'd0);
        chk("reset_busy", 32'(flush_busy), 32'd0);
        chk("reset_rv", 32'(rif.redirect_valid), 32'd0);
        chk("reset_pc", rif.redirect_pc, 32'd0);
        resetn = 1;
        tick();

        // Table: single flush with ready held high, no cacop wait
        for (int k = 0; k < 6; k++) begin
            excp_flush = vecs[k].e; ertn_flush = vecs[k].r; icacop_flush = vecs[k].i;
            refetch_flush = vecs[k].f; excp_tlbrefill = vecs[k].tlb; ws_pc = vecs[k].pc;
            csr_eentry = vecs[k].eent; csr_tlbrentry = vecs[k].tlbr; csr_era_value = vecs[k].era;
            redirect_ready = 1;
            tick();
            t0 = cyc; pf_n = pipe_flush ? 1 : 0; rv_at = -1; idle_at = -1;
            got_pc = 32'd0; got_cause = 2'd0;
            clear_flush();
            for (int j = 0; j < 10; j++) begin
                icache_cacop_done = vecs[k].done && (j == 0);
                tick();
                if (pipe_flush) pf_n++;
                if (rif.redirect_valid && rv_at < 0) begin
                    rv_at = cyc - t0; got_pc = rif.redirect_pc; got_cause = rif.flush_cause;
                end
                if (!flush_busy && idle_at < 0) idle_at = cyc - t0;
            end
            icache_cacop_done = 0;
            chk($sformatf("vec%0d_pipe_flush_cycles", k), 32'(pf_n), 32'(HOLD));
            chk($sformatf("vec%0d_redirect_latency", k), 32'(rv_at), 32'(HOLD));
            chk($sformatf("vec%0d_busy_fall", k), 32'(idle_at), 32'(HOLD + 1));
            chk($sformatf("vec%0d_redirect_pc", k), got_pc, vecs[k].exp_pc);
            chk($sformatf("vec%0d_cause", k), 32'(got_cause), 32'(vecs[k].exp_cause));
        end

        // Refetch wrap, fetch stalls the handshake for 3 cycles
        redirect_ready = 0; refetch_flush = 1; ws_pc = 32'hFFFFFFFC;
        tick();
        refetch_flush = 0;
        repeat (HOLD) tick();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (rif.redirect_valid && rif.redirect_pc == 32'h0) n++;
            redirect_ready = (i == 3);
            tick();
        end
        chk("wrap_redirect_hold_cycles", 32'(n), 32'd4);
        chk("wrap_idle_after_handshake", 32'(flush_busy), 32'd0);

        // icacop with done 5 cycles after the flush window closes
        redirect_ready = 1; icacop_flush = 1; ws_pc = 32'h1C000100;
        tick();
        t0 = cyc; rv_at = -1; got_pc = 32'd0;
        icacop_flush = 0;
        for (int j = 1; j <= HOLD + 9; j++) begin
            icache_cacop_done = (j == HOLD + 5);
            tick();
            if (rif.redirect_valid && rv_at < 0) begin rv_at = cyc - t0; got_pc = rif.redirect_pc; end
        end
        icache_cacop_done = 0;
        chk("cacop_wait_latency", 32'(rv_at), 32'(HOLD + 5));
        chk("cacop_wait_pc", got_pc, 32'h1C000104);

        // ertn held in REDIRECT while an exception commit is ignored
        redirect_ready = 0; ertn_flush = 1; csr_era_value = 32'h1C000040;
        tick();
        ertn_flush = 0;
        repeat (HOLD) tick();
        excp_flush = 1; csr_eentry = 32'hDEADBEEC;
        tick();
        excp_flush = 0;
        tick();
        chk("ertn_hold_rv", 32'(rif.redirect_valid), 32'd1);
        chk("ertn_hold_pc", rif.redirect_pc, 32'h1C000040);
        chk("ertn_hold_cause", 32'(rif.flush_cause), 32'd1);
        redirect_ready = 1;
        tick();
        tick();
        chk("ertn_second_event_ignored", 32'(flush_busy), 32'd0);

        // Back-to-back: new flush in the cycle right after the handshake
        refetch_flush = 1; ws_pc = 32'h1C000100;
        tick();
        refetch_flush = 0;
        repeat (HOLD + 1) tick();
        refetch_flush = 1; ws_pc = 32'h1C000200;
        tick();
        refetch_flush = 0;
        chk("b2b_accept_busy", 32'(flush_busy), 32'd1);
        chk("b2b_accept_pc", rif.redirect_pc, 32'h1C000204);
        repeat (HOLD + 3) tick();

        // Asynchronous reset while waiting for cacop
        icacop_flush = 1; ws_pc = 32'h1C000700;
        tick();
        icacop_flush = 0;
        repeat (HOLD + 1) tick();
        chk("wait_cacop_busy", 32'(flush_busy), 32'd1);
        #2 resetn = 0;
        #1;
        chk("async_rst_pipe_flush", 32'(pipe_flush), 32'd0);
        chk("async_rst_busy", 32'(flush_busy), 32'd0);
        chk("async_rst_rv", 32'(rif.redirect_valid), 32'd0);
        chk("async_rst_pc", rif.redirect_pc, 32'd0);
        chk("async_rst_cause", 32'(rif.flush_cause), 32'd0);
        model_reset();
        repeat (2) tick();
        resetn = 1;
        icache_cacop_done = 1;
        tick();
        icache_cacop_done = 0;
        n = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (rif.redirect_valid) n++;
        end
        chk("no_redirect_after_reset", 32'(n), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            excp_flush     = ($urandom_range(0, 9) == 0);
            ertn_flush     = ($urandom_range(0, 9) == 0);
            icacop_flush   = ($urandom_range(0, 7) == 0);
            refetch_flush  = ($urandom_range(0, 7) == 0);
            excp_tlbrefill = $urandom_range(0, 1) == 1;
            ws_pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            csr_eentry     = $urandom();
            csr_tlbrentry  = $urandom();
            csr_era_value  = $urandom();
            icache_cacop_done = ($urandom_range(0, 5) == 0);
            redirect_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        clear_flush();
        icache_cacop_done = 1;
        redirect_ready = 1;
        repeat (HOLD + 4) tick();
        chk("random_drain_idle", 32'(flush_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
